// File: rtl/bram_fifo_ctrl.sv
// FIFO controller over a two-port block RAM (write on B, registered read on A), first-word-fall-through output.
// Latency: push in cycle 0 -> rd_valid/rd_data in cycle 3; sustains one push and one pop per cycle.
// Backpressure: full drops pushes and sets sticky overflow; rd_ack stalls the two-entry output stage.
module bram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              overflow,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W+1:0] level,
    output logic              ram_b_we,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic [DATA_W-1:0] ram_b_write,
    output logic [ADDR_W-1:0] ram_a_addr,
    input  logic [DATA_W-1:0] ram_a_read
);

    logic [ADDR_W:0]   wr_ptr, rd_ptr, ram_count;
    logic [ADDR_W:0]   wr_ptr_n, rd_ptr_n, ram_count_n;
    logic              pending;
    logic [1:0]        occ, occ_n;
    logic [2:0]        occ_sum;
    logic [DATA_W-1:0] out_reg, skid_reg, out_n, skid_n;
    logic [ADDR_W-1:0] a_addr_q;
    logic [ADDR_W+1:0] level_n;
    logic              push, pop, issue;

    assign ram_count   = wr_ptr - rd_ptr;
    assign full        = (ram_count == {1'b1, {ADDR_W{1'b0}}});
    assign push        = wr_en & ~full;
    assign rd_valid    = (occ != 2'd0);
    assign pop         = rd_ack & rd_valid;
    assign rd_data     = out_reg;

    assign ram_b_we    = push;
    assign ram_b_addr  = wr_ptr[ADDR_W-1:0];
    assign ram_b_write = wr_data;

    // occ_sum is the stage occupancy after this cycle's return and pop; an issue
    // is allowed only if the word it fetches will still have a slot to land in.
    assign occ_sum     = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
    assign occ_n       = occ_sum[1:0];
    assign issue       = (ram_count != '0) && (occ_sum < 3'd2);
    assign ram_a_addr  = issue ? rd_ptr[ADDR_W-1:0] : a_addr_q;

    assign wr_ptr_n    = wr_ptr + {{ADDR_W{1'b0}}, push};
    assign rd_ptr_n    = rd_ptr + {{ADDR_W{1'b0}}, issue};
    assign ram_count_n = wr_ptr_n - rd_ptr_n;
    assign level_n     = {1'b0, ram_count_n} + {{(ADDR_W+1){1'b0}}, issue}
                       + {{ADDR_W{1'b0}}, occ_n};

    always_comb begin
        out_n  = out_reg;
        skid_n = skid_reg;
        if (pop && occ == 2'd2) begin
            out_n = skid_reg;
            if (pending) skid_n = ram_a_read;
        end else if (pending) begin
            if (occ == 2'd0 || pop) out_n  = ram_a_read;
            else                    skid_n = ram_a_read;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= 1'b0;
            occ      <= 2'd0;
            out_reg  <= '0;
            skid_reg <= '0;
            a_addr_q <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= 1'b0;
            occ      <= 2'd0;
            out_reg  <= '0;
            skid_reg <= '0;
            a_addr_q <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            pending  <= issue;
            occ      <= occ_n;
            out_reg  <= out_n;
            skid_reg <= skid_n;
            a_addr_q <= ram_a_addr;
            level    <= level_n;
            overflow <= overflow | (wr_en & full);
        end
    end

endmodule
